// File: rtl/fifo_wr_arbiter_ctrl.sv
// FIFO controller: round-robin write arbitration, pointers and flags.
// Optional almost_full/almost_empty outputs under FIFO_ALMOST_FLAGS_EN.
module fifo_wr_arbiter_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int NREQ      = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_SIZE-1:0] req_data,
  output logic [NREQ-1:0]           gnt,
  input  logic                      rd_en,
  output logic [DATA_SIZE-1:0]      mem_wdata,
  output logic [ADDR_SIZE-1:0]      mem_waddr,
  output logic                      mem_wclk_en,
  output logic                      mem_wfull,
  output logic [ADDR_SIZE-1:0]      mem_raddr,
  output logic                      full,
  output logic                      empty,
  output logic [ADDR_SIZE:0]        count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                      almost_full,
  output logic                      almost_empty
`endif
);

  localparam int RRW = $clog2(NREQ);

  logic [ADDR_SIZE:0] wptr_q, wptr_d;
  logic [ADDR_SIZE:0] rptr_q, rptr_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic [RRW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [RRW-1:0]     gnt_idx;
  logic [RRW-1:0]     idx;
  logic               found;
  logic               wr, rd;

  // Round-robin search from rr_ptr upward with wrap; blocked when full.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = rr_ptr_q;
    if (wrst_n && !full_q) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt[idx]   = 1'b1;
          gnt_idx    = idx;
        end
        idx = (idx == RRW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Route the granted requester's word to the memory write port.
  always_comb begin
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_wdata = mem_wdata | req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign wr = |gnt;
  assign rd = rd_en & ~empty_q;

  // Next-state pointers; flags derive from the next pointers.
  always_comb begin
    wptr_d   = wptr_q + {{ADDR_SIZE{1'b0}}, wr};
    rptr_d   = rptr_q + {{ADDR_SIZE{1'b0}}, rd};
    count_d  = wptr_d - rptr_d;
    empty_d  = (wptr_d == rptr_d);
    full_d   = (wptr_d[ADDR_SIZE] != rptr_d[ADDR_SIZE]) &&
               (wptr_d[ADDR_SIZE-1:0] == rptr_d[ADDR_SIZE-1:0]);
    rr_ptr_d = rr_ptr_q;
    if (wr) begin
      rr_ptr_d = (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  logic af_q, ae_q;

  // Threshold flags track the same next-state occupancy as count.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= (ADDR_SIZE+1)'(AF_LEVEL));
      ae_q <= (count_d <= (ADDR_SIZE+1)'(AE_LEVEL));
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`endif

  assign mem_waddr   = wptr_q[ADDR_SIZE-1:0];
  assign mem_raddr   = rptr_q[ADDR_SIZE-1:0];
  assign mem_wclk_en = wr;
  assign mem_wfull   = full_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Directed bench for fifo_wr_arbiter_ctrl with a behavioural fifo_mem.
// Define FIFO_ALMOST_FLAGS_EN to also exercise the almost flags.
module tb_fifo_wr_arbiter_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 4;
  localparam int DEPTH = 1 << AW;

  logic            wclk;
  logic            wrst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            rd_en;
  logic [DW-1:0]   mem_wdata;
  logic [AW-1:0]   mem_waddr;
  logic            mem_wclk_en;
  logic            mem_wfull;
  logic [AW-1:0]   mem_raddr;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic            almost_full;
  logic            almost_empty;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_ctrl #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .NREQ(N),
    .AF_LEVEL(12), .AE_LEVEL(2)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .rd_en(rd_en), .mem_wdata(mem_wdata),
    .mem_waddr(mem_waddr), .mem_wclk_en(mem_wclk_en),
    .mem_wfull(mem_wfull), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .count(count)
`ifdef FIFO_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(posedge wclk) begin
    if (mem_wclk_en && !mem_wfull) mem[mem_waddr] <= mem_wdata;
  end
  assign rdata = mem[mem_raddr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_rst();
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] exp_g [5];
    int wi, ri, maxc;
    logic wr;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    // 1: reset with all requests held, then round-robin order
    wrst_n = 1'b0;
    req = 4'b1111;
    rd_en = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_wen", mem_wclk_en, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    wrst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", gnt, exp_g[k]);
      step();
    end
    req = '0;
    #1;
    chk("rr_count", count, 5);
    chk("rr_empty", empty, 0);
    chk("rr_rdata", rdata, 8'h10);

    // mid-operation reset clears pointers, flags and rr_ptr
    #1;
    wrst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_waddr", mem_waddr, 0);
    wrst_n = 1'b1;
    req = 4'b1001;
    #1;
    chk("mrst_rr", gnt, 4'b0001);
    req = '0;
    step();

    // 2: single requester fills the FIFO
    req = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      set_data(2, 8'h40 + 8'(i));
      #1;
      chk("fill_gnt", gnt, 4'b0100);
      step();
      if (i == 14) begin
        chk("fill15_cnt", count, 15);
        chk("fill15_full", full, 0);
      end
    end
    #1;
    chk("full_flag", full, 1);
    chk("full_count", count, 16);
    chk("full_gnt", gnt, 0);
    chk("full_wen", mem_wclk_en, 0);
    chk("full_wfull", mem_wfull, 1);

    // 3: read while full blocks the write, then it is granted
    req = 4'b0001;
    rd_en = 1'b1;
    #1;
    chk("rf_gnt", gnt, 0);
    chk("rf_rdata", rdata, 8'h40);
    step();
    chk("rf_count", count, 15);
    chk("rf_full", full, 0);
    rd_en = 1'b0;
    #1;
    chk("rf_gnt2", gnt, 4'b0001);
    step();
    chk("rf_count2", count, 16);
    chk("rf_full2", full, 1);
    req = '0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      #1;
      chk("drain_data", rdata,
          (i < 15) ? 32'(8'h41 + 8'(i)) : 32'h10);
      step();
    end
    rd_en = 1'b0;
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // 4: read on empty is ignored; write with read while empty
    pulse_rst();
    rd_en = 1'b1;
    step();
    chk("re_empty", empty, 1);
    chk("re_raddr", mem_raddr, 0);
    chk("re_count", count, 0);
    set_data(0, 8'hA5);
    req = 4'b0001;
    #1;
    chk("we_gnt", gnt, 4'b0001);
    step();
    chk("we_count", count, 1);
    chk("we_empty", empty, 0);
    chk("we_rdata", rdata, 8'hA5);
    req = '0;
    step();
    chk("we_empty2", empty, 1);
    rd_en = 1'b0;

    // 5: streaming 40 words through pointer wrap
    pulse_rst();
    wi = 0;
    ri = 0;
    maxc = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      req[1] = (wi < 40);
      set_data(1, 8'(wi));
      rd_en = (cyc >= 10) && !empty;
      #1;
      if (rd_en) chk("stream_data", rdata, ri);
      wr = gnt[1];
      step();
      if (wr) wi++;
      if (rd_en) ri++;
      if (int'(count) > maxc) maxc = int'(count);
      if (ri >= 40) break;
    end
    req = '0;
    rd_en = 1'b0;
    chk("stream_wr", wi, 40);
    chk("stream_rd", ri, 40);
    chk("stream_maxok", (maxc <= 16), 1);
    #1;
    chk("stream_empty", empty, 1);

`ifdef FIFO_ALMOST_FLAGS_EN
    // 6: almost-full and almost-empty thresholds
    pulse_rst();
    chk("al_rst_af", almost_full, 0);
    chk("al_rst_ae", almost_empty, 1);
    req = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 10) chk("al_af11", almost_full, 0);
    end
    req = '0;
    #1;
    chk("al_count12", count, 12);
    chk("al_af12", almost_full, 1);
    chk("al_ae12", almost_empty, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 8) chk("al_ae3", almost_empty, 0);
    end
    rd_en = 1'b0;
    #1;
    chk("al_count2", count, 2);
    chk("al_ae2", almost_empty, 1);
    chk("al_af2", almost_full, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
